// File: rtl/seq_word_compare_pkg.sv
// Shared types and helpers for the sliced magnitude comparator.
// Optional signed compare is enabled by SEQ_WORD_COMPARE_SIGNED_EN.
package seq_word_compare_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Result vector is packed as {gt, lt, eq}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

  function automatic int unsigned calc_nchunk(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_word_compare_if.sv
// Start/done handshake and operand/result bundle for seq_word_compare.
// signed_mode exists only when SEQ_WORD_COMPARE_SIGNED_EN is defined.
interface seq_word_compare_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
  logic             signed_mode;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
    output signed_mode,
`endif
    output start, a, b,
    input  ready, busy, done, gt, lt, eq
  );

  modport slave (
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
    input  signed_mode,
`endif
    input  start, a, b,
    output ready, busy, done, gt, lt, eq
  );

endinterface

// File: rtl/seq_word_compare_slice_cmp.sv
// Combinational CHUNK-bit unsigned comparator for one operand slice.
module slice_cmp #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/seq_word_compare.sv
// Multi-cycle magnitude comparator: one CHUNK slice per cycle, MSB first, early exit.
// Define SEQ_WORD_COMPARE_SIGNED_EN to add a two's-complement signed_mode input.
module seq_word_compare
  import seq_word_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  seq_word_compare_if.slave bus
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] msb_flip;
  logic             s_gt, s_lt, s_eq;

  // Inverting the sign bit of both operands maps two's complement onto
  // offset-binary, so the unsigned slice compare orders signed values.
  always_comb begin
    msb_flip = '0;
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
    msb_flip[WIDTH-1] = bus.signed_mode;
`endif
  end

  slice_cmp #(
    .CHUNK(CHUNK)
  ) u_slice_cmp (
    .a (a_q[WIDTH-1 -: CHUNK]),
    .b (b_q[WIDTH-1 -: CHUNK]),
    .gt(s_gt),
    .lt(s_lt),
    .eq(s_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a ^ msb_flip;
          b_d     = bus.b ^ msb_flip;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!s_eq) begin
          res_d   = {s_gt, s_lt, 1'b0};
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LAST_IDX) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign {bus.gt, bus.lt, bus.eq} = res_q;

endmodule

// File: tb/tb_seq_word_compare.sv
// Scoreboard bench: directed vectors on CHUNK=8, model-checked sweeps on CHUNK=32 and CHUNK=1.
module tb_seq_word_compare;
  import seq_word_compare_pkg::*;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
    logic       sm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  logic        start_s [3];
  logic [31:0] a_s     [3];
  logic [31:0] b_s     [3];
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
  logic        sm_s    [3];
`endif
  logic        ready_s [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [2:0]  res_s   [3];

  exp_t exp_q [3][$];

  seq_word_compare_if #(.WIDTH(32)) bus [3] ();

  seq_word_compare #(.WIDTH(32), .CHUNK(8))  dut   (.clk(clk), .rst(rst), .bus(bus[0]));
  seq_word_compare #(.WIDTH(32), .CHUNK(32)) dut_w (.clk(clk), .rst(rst), .bus(bus[1]));
  seq_word_compare #(.WIDTH(32), .CHUNK(1))  dut_n (.clk(clk), .rst(rst), .bus(bus[2]));

  for (genvar k = 0; k < 3; k++) begin : g_bus
    assign bus[k].start = start_s[k];
    assign bus[k].a     = a_s[k];
    assign bus[k].b     = b_s[k];
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
    assign bus[k].signed_mode = sm_s[k];
`endif
    assign ready_s[k] = bus[k].ready;
    assign busy_s[k]  = bus[k].busy;
    assign done_s[k]  = bus[k].done;
    assign res_s[k]   = {bus[k].gt, bus[k].lt, bus[k].eq};

    always @(negedge clk) begin
      if (!rst && done_s[k]) begin
        nvec++;
        if (exp_q[k].size() == 0) begin
          nerr++;
          $display("FAIL spurious_done dut%0d: done=1 with nothing outstanding, flags=%b", k, res_s[k]);
        end else begin
          exp_t e;
          e = exp_q[k].pop_front();
          if (res_s[k] !== e.res) begin
            nerr++;
            $display("FAIL flags dut%0d sm=%0b: got {gt,lt,eq}=%b expected %b", k, e.sm, res_s[k], e.res);
          end
          nvec++;
          if (cyc - e.acc != e.lat) begin
            nerr++;
            $display("FAIL latency dut%0d: got %0d cycles expected %0d", k, cyc - e.acc, e.lat);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic sm, input logic [2:0] res, input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!ready_s[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s[k]) begin
      nvec++;
      nerr++;
      $display("FAIL ready_timeout dut%0d: ready=0 expected 1", k);
    end
    start_s[k] = 1'b1;
    a_s[k]     = av;
    b_s[k]     = bv;
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
    sm_s[k]    = sm;
`endif
    e.res = res;
    e.lat = lat;
    e.acc = cyc + 1;
    e.sm  = sm;
    if (push) exp_q[k].push_back(e);
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
  endtask

  function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                                input int c, output logic [2:0] res, output int lat);
    logic [31:0] x, y;
    logic [63:0] xs, ys, m;
    bit          found;
    int          n;
    x = av;
    y = bv;
    if (sm) begin
      x[31] = ~x[31];
      y[31] = ~y[31];
    end
    n     = 32 / c;
    m     = (64'd1 << c) - 64'd1;
    res   = RES_EQ;
    lat   = n;
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      xs = ({32'd0, x} >> (32 - (i + 1) * c)) & m;
      ys = ({32'd0, y} >> (32 - (i + 1) * c)) & m;
      if (!found && xs != ys) begin
        found = 1'b1;
        res   = (xs > ys) ? RES_GT : RES_LT;
        lat   = i + 1;
      end
    end
  endfunction

  initial begin
    logic [2:0]  r;
    logic [31:0] av, bv;
    logic        sm;
    int          lat, n;

    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      a_s[k]     = '0;
      b_s[k]     = '0;
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
      sm_s[k]    = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready_s[0]), 32'd1);
    check("reset_busy",  32'(busy_s[0]),  32'd0);
    check("reset_done",  32'(done_s[0]),  32'd0);
    check("reset_flags", 32'(res_s[0]),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Equal operands run the full four slices.
    issue(0, 32'h12345678, 32'h12345678, 1'b0, RES_EQ, 4, 1'b1);
    check("busy_after_accept", 32'(busy_s[0]), 32'd1);
    check("ready_after_accept", 32'(ready_s[0]), 32'd0);
    drain();

    issue(0, 32'h80000000, 32'h7FFFFFFF, 1'b0, RES_GT, 1, 1'b1);
    drain();
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
    issue(0, 32'h80000000, 32'h7FFFFFFF, 1'b1, RES_LT, 1, 1'b1);
    drain();
`endif

    // Second compare issued in the cycle the first reports done.
    issue(0, 32'h123456FF, 32'h12345600, 1'b0, RES_GT, 4, 1'b1);
    n = 0;
    while (!done_s[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(done_s[0]), 32'd1);
    check("b2b_ready_with_done", 32'(ready_s[0]), 32'd1);
    issue(0, 32'h00000001, 32'h00000002, 1'b0, RES_LT, 4, 1'b1);
    drain();

    // Starts while busy must be ignored.
    issue(0, 32'hAA000000, 32'hAB000000, 1'b0, RES_LT, 1, 1'b1);
    n = 0;
    while (busy_s[0] && n < 20) begin
      start_s[0] = 1'b1;
      a_s[0]     = $urandom;
      b_s[0]     = $urandom;
      @(negedge clk);
      n++;
    end
    start_s[0] = 1'b0;
    repeat (6) @(negedge clk);
    drain();
    check("flags_hold", 32'(res_s[0]), 32'(RES_LT));

    // Reset during the second RUN cycle of an equal compare.
    issue(0, 32'h55555555, 32'h55555555, 1'b0, RES_EQ, 4, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_flags", 32'(res_s[0]), 32'd0);
    check("abort_ready", 32'(ready_s[0]), 32'd1);
    check("abort_busy",  32'(busy_s[0]),  32'd0);
    @(negedge clk);
    check("abort_no_done", 32'(done_s[0]), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    issue(0, 32'h00010000, 32'h00020000, 1'b0, RES_LT, 2, 1'b1);
    drain();

    // Sweep CHUNK=32 (dut1) and CHUNK=1 (dut2) against the reference model.
    for (int k = 1; k < 3; k++) begin
      for (int t = 0; t < 12; t++) begin
        av = $urandom;
        case (t % 3)
          0:       bv = av;
          1:       bv = $urandom;
          default: bv = av ^ (32'h1 << $urandom_range(0, 31));
        endcase
`ifdef SEQ_WORD_COMPARE_SIGNED_EN
        sm = 1'($urandom_range(0, 1));
`else
        sm = 1'b0;
`endif
        model(av, bv, sm, (k == 1) ? 32 : 1, r, lat);
        issue(k, av, bv, sm, r, lat, 1'b1);
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
